bnn_pixel_loader: RTL and testbench

- Input-loading stage directly upstream of the pixel/weight register bank, active while the top-level FSM sits in its LOAD state (state == 1).
- Receives a binarized 28x28 MNIST image from the dedicated input pins, 8 pixels per byte, qualified by an asynchronous strobe pin.
- Assembles the bytes into a flat 784-bit pixel vector and raises `load_done` to advance the FSM.

---
 rtl/bnn_pixel_loader.sv | 99 +++++++++
 tb/tb_bnn_pixel_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_pixel_loader.sv
// Input-loading stage: collects NUM_BYTES strobed bytes from the input pins
// into a flat pixel vector and flags load_done for the top-level FSM.
module bnn_pixel_loader #(
  parameter  int N_PIXELS  = 784,
  parameter  int BYTE_W    = 8,
  localparam int NUM_BYTES = N_PIXELS / BYTE_W,
  localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [BYTE_W-1:0]   data_in,
  input  logic                data_strobe,
  output logic                load_done,
  output logic                busy,
  output logic [CNT_W-1:0]    byte_count,
  output logic [N_PIXELS-1:0] pixels,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic   s1, s2, s3;
  logic   accept;
  logic   last_byte;

  // Handshake: data_strobe acts as a valid with no ready. One byte is taken
  // per synchronised rising edge, and only while in RECV; the source must
  // keep data_in stable for 3 clk cycles after raising the strobe.
  assign accept    = s2 & ~s3 & (state == RECV);
  assign last_byte = (byte_count == CNT_W'(NUM_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RECV;
      RECV: begin
        if (!en) begin
          state_next = IDLE;
        end else if (accept && last_byte) begin
          state_next = DONE;
        end
      end
      DONE: if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      byte_count <= '0;
      pixels     <= '0;
    end else begin
      s1 <= data_strobe;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (en) begin
            byte_count <= '0;
            pixels     <= '0;
          end
        end
        RECV: begin
          // An abort takes priority over a byte landing on the same edge.
          if (!en) begin
            byte_count <= '0;
          end else if (accept) begin
            pixels[int'(byte_count) * BYTE_W +: BYTE_W] <= data_in;
            byte_count <= byte_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state == RECV);
  assign load_done = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bnn_pixel_loader.sv
// Bench for bnn_pixel_loader: scenario tasks check the DUT against a
// byte-queue model of the load protocol.
module tb_bnn_pixel_loader;

  localparam int NP = 784;
  localparam int BW = 8;
  localparam int NB = NP / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic          data_strobe = 1'b0;
  logic          load_done;
  logic          busy;
  logic [6:0]    byte_count;
  logic [NP-1:0] pixels;
  logic [1:0]    state_dbg;

  int cmp_count = 0;
  int err_count = 0;

  // Model: phase 0 = not loading, 1 = loading, 2 = load complete.
  logic [BW-1:0] exp_q[$];
  int            exp_count = 0;
  int            phase = 0;

  bnn_pixel_loader dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .data_strobe(data_strobe), .load_done(load_done), .busy(busy),
    .byte_count(byte_count), .pixels(pixels), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] model_pixels();
    logic [NP-1:0] v = '0;
    for (int i = 0; i < exp_q.size(); i++) v[i*BW +: BW] = exp_q[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_count = 0;
    phase = 0;
  endtask

  task automatic set_en(input logic v);
    en = v;
    if (v && phase == 0) begin
      phase = 1;
      exp_q.delete();
      exp_count = 0;
    end else if (!v) begin
      if (phase == 1) exp_count = 0;
      phase = 0;
    end
    tick(1);
  endtask

  task automatic send_byte(input logic [BW-1:0] b, input int hi, input int lo);
    data_in = b;
    data_strobe = 1'b1;
    if (phase == 1 && en) begin
      exp_q.push_back(b);
      exp_count++;
      if (exp_count == NB) phase = 2;
    end
    tick(hi);
    data_strobe = 1'b0;
    tick(lo);
  endtask

  task automatic send_rand(input logic [BW-1:0] b);
    send_byte(b, $urandom_range(3, 6), $urandom_range(2, 5));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    tick(2);
    model_reset();
    cmp_count += 5;
    if (load_done !== 1'b0) begin err_count++; $display("FAIL reset_load_done got %b want 0", load_done); end
    if (busy !== 1'b0) begin err_count++; $display("FAIL reset_busy got %b want 0", busy); end
    if (byte_count !== 7'd0) begin err_count++; $display("FAIL reset_count got %0d want 0", byte_count); end
    if (pixels !== '0) begin err_count++; $display("FAIL reset_pixels got %h want 0", pixels); end
    if (state_dbg !== 2'd0) begin err_count++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_full_load();
    set_en(1'b1);
    cmp_count++;
    if (busy !== 1'b1) begin err_count++; $display("FAIL full_busy_start got %b want 1", busy); end
    for (int i = 0; i < NB - 1; i++) send_byte(BW'(i), 4, 4);
    data_in = 8'h61;
    data_strobe = 1'b1;
    exp_q.push_back(8'h61);
    exp_count++;
    phase = 2;
    for (int e = 0; e < 3; e++) begin
      tick(1);
      cmp_count++;
      if (load_done !== (e == 2)) begin
        err_count++;
        $display("FAIL full_latency edge k+%0d got %b want %b", e, load_done, (e == 2));
      end
    end
    tick(1);
    data_strobe = 1'b0;
    tick(4);
    cmp_count += 6;
    if (byte_count !== 7'(exp_count)) begin err_count++; $display("FAIL full_count got %0d want %0d", byte_count, exp_count); end
    if (pixels[7:0] !== 8'h00) begin err_count++; $display("FAIL full_byte0 got %h want 00", pixels[7:0]); end
    if (pixels[15:8] !== 8'h01) begin err_count++; $display("FAIL full_byte1 got %h want 01", pixels[15:8]); end
    if (pixels[783:776] !== 8'h61) begin err_count++; $display("FAIL full_byte97 got %h want 61", pixels[783:776]); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL full_pixels got %h want %h", pixels, model_pixels()); end
    if (busy !== 1'b0) begin err_count++; $display("FAIL full_busy_end got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 4, 4);
    cmp_count += 3;
    if (byte_count !== 7'd98) begin err_count++; $display("FAIL ovf_count got %0d want 98", byte_count); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL ovf_pixels got %h want %h", pixels, model_pixels()); end
    if (load_done !== 1'b1) begin err_count++; $display("FAIL ovf_load_done got %b want 1", load_done); end
  endtask

  task automatic test_done_exit();
    logic [NP-1:0] held;
    held = model_pixels();
    set_en(1'b0);
    cmp_count += 3;
    if (load_done !== 1'b0) begin err_count++; $display("FAIL exit_load_done got %b want 0", load_done); end
    if (busy !== 1'b0) begin err_count++; $display("FAIL exit_busy got %b want 0", busy); end
    if (pixels !== held) begin err_count++; $display("FAIL exit_pixels got %h want %h", pixels, held); end
  endtask

  task automatic test_long_strobe();
    set_en(1'b1);
    send_byte(8'hA5, 20, 4);
    cmp_count += 3;
    if (byte_count !== 7'(exp_count)) begin err_count++; $display("FAIL long_count got %0d want %0d", byte_count, exp_count); end
    if (byte_count !== 7'd1) begin err_count++; $display("FAIL long_count1 got %0d want 1", byte_count); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL long_pixels got %h want %h", pixels, model_pixels()); end
  endtask

  task automatic test_abort();
    logic [79:0] pat;
    set_en(1'b0);
    set_en(1'b1);
    for (int i = 0; i < 10; i++) send_rand(8'h3C);
    pat = {10{8'h3C}};
    set_en(1'b0);
    cmp_count += 4;
    if (state_dbg !== 2'd0) begin err_count++; $display("FAIL abort_state got %0d want 0", state_dbg); end
    if (byte_count !== 7'd0) begin err_count++; $display("FAIL abort_count got %0d want 0", byte_count); end
    if (pixels[79:0] !== pat) begin err_count++; $display("FAIL abort_partial got %h want %h", pixels[79:0], pat); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL abort_pixels got %h want %h", pixels, model_pixels()); end
    set_en(1'b1);
    cmp_count += 2;
    if (pixels !== '0) begin err_count++; $display("FAIL reentry_pixels got %h want 0", pixels); end
    if (busy !== 1'b1) begin err_count++; $display("FAIL reentry_busy got %b want 1", busy); end
  endtask

  task automatic test_abort_final_collide();
    logic [NP-1:0] held;
    set_en(1'b0);
    set_en(1'b1);
    for (int i = 0; i < NB - 1; i++) send_rand(BW'($urandom));
    held = model_pixels();
    data_in = BW'($urandom);
    data_strobe = 1'b1;
    tick(2);
    en = 1'b0;
    phase = 0;
    exp_count = 0;
    tick(1);
    cmp_count += 3;
    if (load_done !== 1'b0) begin err_count++; $display("FAIL collide_load_done got %b want 0", load_done); end
    if (busy !== 1'b0) begin err_count++; $display("FAIL collide_busy got %b want 0", busy); end
    if (byte_count !== 7'd0) begin err_count++; $display("FAIL collide_count got %0d want 0", byte_count); end
    data_strobe = 1'b0;
    tick(4);
    cmp_count += 2;
    if (load_done !== 1'b0) begin err_count++; $display("FAIL collide_later got %b want 0", load_done); end
    if (pixels !== held) begin err_count++; $display("FAIL collide_pixels got %h want %h", pixels, held); end
  endtask

  task automatic test_reset_mid();
    set_en(1'b1);
    for (int i = 0; i < 50; i++) send_rand(BW'($urandom));
    cmp_count++;
    if (byte_count !== 7'd50) begin err_count++; $display("FAIL mid_count_pre got %0d want 50", byte_count); end
    rst = 1'b1;
    en = 1'b0;
    tick(1);
    model_reset();
    rst = 1'b0;
    cmp_count += 4;
    if (byte_count !== 7'd0) begin err_count++; $display("FAIL mid_count got %0d want 0", byte_count); end
    if (pixels !== '0) begin err_count++; $display("FAIL mid_pixels got %h want 0", pixels); end
    if (busy !== 1'b0 || load_done !== 1'b0) begin err_count++; $display("FAIL mid_flags got %b%b want 00", busy, load_done); end
    if (state_dbg !== 2'd0) begin err_count++; $display("FAIL mid_state got %0d want 0", state_dbg); end
    send_byte(8'h5A, 4, 4);
    cmp_count += 2;
    if (byte_count !== 7'(exp_count)) begin err_count++; $display("FAIL mid_strobe_count got %0d want %0d", byte_count, exp_count); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL mid_strobe_pixels got %h want %h", pixels, model_pixels()); end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      send_rand(BW'($urandom));
      cmp_count++;
      if (byte_count !== 7'd0) begin err_count++; $display("FAIL idle_count[%0d] got %0d want 0", i, byte_count); end
    end
  endtask

  task automatic test_random_load();
    set_en(1'b1);
    for (int i = 0; i < NB; i++) begin
      send_rand(BW'($urandom));
      if (i % 16 == 7) begin
        cmp_count++;
        if (byte_count !== 7'(exp_count)) begin err_count++; $display("FAIL rand_count got %0d want %0d", byte_count, exp_count); end
      end
    end
    cmp_count += 3;
    if (load_done !== 1'b1) begin err_count++; $display("FAIL rand_load_done got %b want 1", load_done); end
    if (byte_count !== 7'(exp_count)) begin err_count++; $display("FAIL rand_final_count got %0d want %0d", byte_count, exp_count); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL rand_pixels got %h want %h", pixels, model_pixels()); end
    en = 1'b0;
    phase = 0;
    tick(1);
    cmp_count += 2;
    if (load_done !== 1'b0) begin err_count++; $display("FAIL rand_exit got %b want 0", load_done); end
    if (pixels !== model_pixels()) begin err_count++; $display("FAIL rand_hold got %h want %h", pixels, model_pixels()); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_full_load();
    test_overflow();
    test_done_exit();
    test_long_strobe();
    test_abort();
    test_abort_final_collide();
    test_reset_mid();
    test_idle_ignore();
    test_random_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
